// File: rtl/out_vc_state_pkg.sv
// Shared constants, VC state encoding and error bit indices for the per-output-port VC tracker.
// The optional AGGRESSIVE_VC_REALLOC_EN macro (see out_vc_slot) changes only slot behaviour.
package out_vc_state_pkg;

  localparam int NUM_VC    = 4;
  localparam int BUF_DEPTH = 4;
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam int VW        = $clog2(NUM_VC);
  localparam int ERR_W     = 3;

  localparam int ERR_UFL   = 0;
  localparam int ERR_OFL   = 1;
  localparam int ERR_PROTO = 2;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ACTIVE = 2'd1,
    VC_DRAIN  = 2'd2
  } vc_state_e;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic valid, input logic [VW-1:0] vc);
    logic [NUM_VC-1:0] hot;
    hot = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      hot[i] = valid && (vc == VW'(i));
    end
    return hot;
  endfunction

endpackage

// File: rtl/out_vc_state_if.sv
// Bundle of allocator claims, flit/credit events and VC status outputs for one output port.
// master drives the events and observes status; slave is the VC state tracker.
interface out_vc_state_if;
  import out_vc_state_pkg::*;

  logic [NUM_VC-1:0]    outVCAvailableReset;
  logic                 flit_valid;
  logic [VW-1:0]        flit_vc;
  logic                 flit_tail;
  logic                 credit_valid;
  logic [VW-1:0]        credit_vc;
  logic [NUM_VC-1:0]    outVCAvailable;
  logic [NUM_VC-1:0]    vc_has_credit;
  logic [NUM_VC*CW-1:0] credit_cnt;
  logic [ERR_W-1:0]     err;

  modport master (
    output outVCAvailableReset, flit_valid, flit_vc, flit_tail, credit_valid, credit_vc,
    input  outVCAvailable, vc_has_credit, credit_cnt, err
  );

  modport slave (
    input  outVCAvailableReset, flit_valid, flit_vc, flit_tail, credit_valid, credit_vc,
    output outVCAvailable, vc_has_credit, credit_cnt, err
  );

endinterface

// File: rtl/out_vc_slot.sv
// One downstream VC: IDLE/ACTIVE/DRAIN state machine plus its credit counter.
// With AGGRESSIVE_VC_REALLOC_EN defined the DRAIN state is skipped and a tail frees the VC at once.
module out_vc_slot
  import out_vc_state_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          claim,
  input  logic          flit_hit,
  input  logic          tail,
  input  logic          credit_hit,
  output logic          available,
  output logic          has_credit,
  output logic [CW-1:0] cnt,
  output logic          ufl,
  output logic          ofl,
  output logic          proto
);

  vc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          available_q, available_d;
  logic          has_credit_q, has_credit_d;

  // A same-cycle flit and credit cancel, so neither bound can be crossed then.
  always_comb begin
    cnt_d = cnt_q;
    ufl   = 1'b0;
    ofl   = 1'b0;
    if (flit_hit && !credit_hit) begin
      if (cnt_q == '0) begin
        ufl = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (credit_hit && !flit_hit) begin
      if (cnt_q == CREDIT_MAX) begin
        ofl = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    proto   = 1'b0;
    unique case (state_q)
      VC_IDLE: begin
`ifndef AGGRESSIVE_VC_REALLOC_EN
        if (flit_hit) begin
          proto = 1'b1;
        end
`endif
        if (claim) begin
          state_d = VC_ACTIVE;
        end
      end
      VC_ACTIVE: begin
        if (claim) begin
          proto = 1'b1;
        end
        if (flit_hit && tail) begin
`ifdef AGGRESSIVE_VC_REALLOC_EN
          state_d = VC_IDLE;
`else
          state_d = VC_DRAIN;
`endif
        end
      end
`ifndef AGGRESSIVE_VC_REALLOC_EN
      VC_DRAIN: begin
        if (claim || flit_hit) begin
          proto = 1'b1;
        end
        if (cnt_d == CREDIT_MAX) begin
          state_d = VC_IDLE;
        end
      end
`endif
      default: begin
        state_d = VC_IDLE;
      end
    endcase
  end

  always_comb begin
    available_d  = (state_d == VC_IDLE);
    has_credit_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= VC_IDLE;
      cnt_q        <= CREDIT_MAX;
      available_q  <= 1'b1;
      has_credit_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      available_q  <= available_d;
      has_credit_q <= has_credit_d;
    end
  end

  assign available  = available_q;
  assign has_credit = has_credit_q;
  assign cnt        = cnt_q;

endmodule

// File: rtl/out_vc_state.sv
// Per-output-port VC state and credit tracker: one out_vc_slot per VC plus sticky error flags.
// Honours AGGRESSIVE_VC_REALLOC_EN through the slots.
module out_vc_state
  import out_vc_state_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  out_vc_state_if.slave  bus
);

  logic [NUM_VC-1:0]    flit_hit;
  logic [NUM_VC-1:0]    credit_hit;
  logic [NUM_VC-1:0]    available;
  logic [NUM_VC-1:0]    has_credit;
  logic [NUM_VC-1:0]    ufl;
  logic [NUM_VC-1:0]    ofl;
  logic [NUM_VC-1:0]    proto;
  logic [NUM_VC*CW-1:0] cnt_flat;
  logic [ERR_W-1:0]     err_q, err_d;

  always_comb begin
    flit_hit   = vc_onehot(bus.flit_valid, bus.flit_vc);
    credit_hit = vc_onehot(bus.credit_valid, bus.credit_vc);
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_slot
    out_vc_slot u_slot (
      .clk        (clk),
      .rstn       (rstn),
      .claim      (bus.outVCAvailableReset[g]),
      .flit_hit   (flit_hit[g]),
      .tail       (bus.flit_tail),
      .credit_hit (credit_hit[g]),
      .available  (available[g]),
      .has_credit (has_credit[g]),
      .cnt        (cnt_flat[g*CW +: CW]),
      .ufl        (ufl[g]),
      .ofl        (ofl[g]),
      .proto      (proto[g])
    );
  end

  // Error flags accumulate until the next reset.
  always_comb begin
    err_d            = err_q;
    err_d[ERR_UFL]   = err_q[ERR_UFL]   | (|ufl);
    err_d[ERR_OFL]   = err_q[ERR_OFL]   | (|ofl);
    err_d[ERR_PROTO] = err_q[ERR_PROTO] | (|proto);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.outVCAvailable = available;
  assign bus.vc_has_credit  = has_credit;
  assign bus.credit_cnt     = cnt_flat;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_out_vc_state.sv
// Scoreboard bench for out_vc_state: a behavioural VC model predicts every registered output.
// Directed scenarios depend on AGGRESSIVE_VC_REALLOC_EN; a random phase follows in both builds.
module tb_out_vc_state;
  import out_vc_state_pkg::*;

  typedef struct {
    logic [NUM_VC-1:0]    avail;
    logic [NUM_VC-1:0]    hc;
    logic [NUM_VC*CW-1:0] cnt;
    logic [ERR_W-1:0]     err;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t expQ[$];
  int   mState[NUM_VC];
  int   mCnt[NUM_VC];
  logic [ERR_W-1:0] mErr;

  out_vc_state_if bus ();

  out_vc_state dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  // State codes in the model: 0 idle, 1 active, 2 drain.
  task automatic modelStep(input logic r, input logic [NUM_VC-1:0] claim, input logic fv,
                           input logic [VW-1:0] fvc, input logic ft, input logic cv, input logic [VW-1:0] cvc);
    if (!r) begin
      for (int i = 0; i < NUM_VC; i++) begin
        mState[i] = 0;
        mCnt[i]   = BUF_DEPTH;
      end
      mErr = '0;
      return;
    end
    for (int i = 0; i < NUM_VC; i++) begin
      bit fh, ch;
      int nc;
      fh = fv && (int'(fvc) == i);
      ch = cv && (int'(cvc) == i);
      nc = mCnt[i];
      if (fh && !ch) begin
        if (mCnt[i] == 0) mErr[0] = 1'b1;
        else nc = mCnt[i] - 1;
      end
      if (ch && !fh) begin
        if (mCnt[i] == BUF_DEPTH) mErr[1] = 1'b1;
        else nc = mCnt[i] + 1;
      end
      case (mState[i])
        0: begin
`ifndef AGGRESSIVE_VC_REALLOC_EN
          if (fh) mErr[2] = 1'b1;
`endif
          if (claim[i]) mState[i] = 1;
        end
        1: begin
          if (claim[i]) mErr[2] = 1'b1;
`ifdef AGGRESSIVE_VC_REALLOC_EN
          if (fh && ft) mState[i] = 0;
`else
          if (fh && ft) mState[i] = 2;
`endif
        end
        default: begin
          if (claim[i] || fh) mErr[2] = 1'b1;
          if (nc == BUF_DEPTH) mState[i] = 0;
        end
      endcase
      mCnt[i] = nc;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NUM_VC-1:0] claim, input logic fv,
                               input logic [VW-1:0] fvc, input logic ft, input logic cv, input logic [VW-1:0] cvc);
    exp_t e, got;
    rstn                    = r;
    bus.outVCAvailableReset = claim;
    bus.flit_valid          = fv;
    bus.flit_vc             = fvc;
    bus.flit_tail           = ft;
    bus.credit_valid        = cv;
    bus.credit_vc           = cvc;
    modelStep(r, claim, fv, fvc, ft, cv, cvc);
    for (int i = 0; i < NUM_VC; i++) begin
      e.avail[i]        = (mState[i] == 0);
      e.hc[i]           = (mCnt[i] != 0);
      e.cnt[i*CW +: CW] = CW'(mCnt[i]);
    end
    e.err = mErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput("outVCAvailable", 32'(bus.outVCAvailable), 32'(got.avail));
    checkOutput("vc_has_credit", 32'(bus.vc_has_credit), 32'(got.hc));
    checkOutput("credit_cnt", 32'(bus.credit_cnt), 32'(got.cnt));
    checkOutput("err", 32'(bus.err), 32'(got.err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic flit(input int vc, input logic tl);
    applyStimulus(1'b1, '0, 1'b1, VW'(vc), tl, 1'b0, '0);
  endtask

  task automatic credit(input int vc);
    applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, VW'(vc));
  endtask

  task automatic claimVcs(input logic [NUM_VC-1:0] c);
    applyStimulus(1'b1, c, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    idle(5);
    checkOutput("reset_avail", 32'(bus.outVCAvailable), 32'h0000_000F);
    checkOutput("reset_cnt", 32'(bus.credit_cnt), 32'h0000_0924);
    checkOutput("reset_err", 32'(bus.err), 32'h0);

`ifdef AGGRESSIVE_VC_REALLOC_EN
    claimVcs(4'b0010);
    flit(1, 1'b0);
    flit(1, 1'b1);
    checkOutput("aggr_avail1", 32'(bus.outVCAvailable[1]), 32'h1);
    checkOutput("aggr_cnt1", 32'(bus.credit_cnt[1*CW +: CW]), 32'h2);
    claimVcs(4'b0010);
    checkOutput("aggr_reclaim_err", 32'(bus.err), 32'h0);
    checkOutput("aggr_reclaim_avail1", 32'(bus.outVCAvailable[1]), 32'h0);
    credit(1);
    credit(1);
`else
    claimVcs(4'b0010);
    checkOutput("claim_avail", 32'(bus.outVCAvailable), 32'hD);
    flit(1, 1'b0);
    flit(1, 1'b0);
    flit(1, 1'b1);
    checkOutput("drain_avail", 32'(bus.outVCAvailable), 32'hD);
    checkOutput("drain_cnt1", 32'(bus.credit_cnt[1*CW +: CW]), 32'h1);
    credit(1);
    credit(1);
    checkOutput("drain_hold_avail1", 32'(bus.outVCAvailable[1]), 32'h0);
    credit(1);
    checkOutput("drain_exit_avail1", 32'(bus.outVCAvailable[1]), 32'h1);
    checkOutput("drain_exit_cnt1", 32'(bus.credit_cnt[1*CW +: CW]), 32'h4);

    claimVcs(4'b0100);
    flit(2, 1'b0);
    flit(2, 1'b0);
    applyStimulus(1'b1, '0, 1'b1, VW'(2), 1'b0, 1'b1, VW'(2));
    checkOutput("net_zero_cnt2", 32'(bus.credit_cnt[2*CW +: CW]), 32'h2);
    checkOutput("net_zero_err", 32'(bus.err), 32'h0);

    claimVcs(4'b1000);
    for (int k = 0; k < 4; k++) flit(3, 1'b0);
    flit(3, 1'b0);
    checkOutput("ufl_cnt3", 32'(bus.credit_cnt[3*CW +: CW]), 32'h0);
    checkOutput("ufl_err", 32'(bus.err), 32'h1);
    checkOutput("ufl_hascredit3", 32'(bus.vc_has_credit[3]), 32'h0);
    idle(2);
    checkOutput("ufl_sticky", 32'(bus.err[ERR_UFL]), 32'h1);

    credit(0);
    checkOutput("ofl_cnt0", 32'(bus.credit_cnt[0*CW +: CW]), 32'h4);
    checkOutput("ofl_err", 32'(bus.err[ERR_OFL]), 32'h1);

    claimVcs(4'b0001);
    claimVcs(4'b0001);
    checkOutput("proto_err", 32'(bus.err[ERR_PROTO]), 32'h1);
    checkOutput("proto_vc0_active", 32'(bus.outVCAvailable[0]), 32'h0);

    claimVcs(4'b1111);
    for (int v = 0; v < NUM_VC; v++) flit(v, 1'b1);
    checkOutput("mid_drain_avail", 32'(bus.outVCAvailable), 32'h0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("midrst_avail", 32'(bus.outVCAvailable), 32'hF);
    checkOutput("midrst_cnt", 32'(bus.credit_cnt), 32'h0000_0924);
    checkOutput("midrst_err", 32'(bus.err), 32'h0);
`endif

    // Random traffic; the model tracks every corner including error paths and resets.
    for (int k = 0; k < 400; k++) begin
      logic r, fv, ft, cv;
      logic [NUM_VC-1:0] c;
      logic [VW-1:0] fvc, cvc;
      r   = ($urandom_range(63) != 0);
      c   = ($urandom_range(3) == 0) ? NUM_VC'($urandom_range(15)) : '0;
      fv  = ($urandom_range(2) == 0);
      fvc = VW'($urandom_range(NUM_VC - 1));
      ft  = ($urandom_range(3) == 0);
      cv  = ($urandom_range(2) == 0);
      cvc = VW'($urandom_range(NUM_VC - 1));
      applyStimulus(r, c, fv, fvc, ft, cv, cvc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
